// File: rtl/ceespu_branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ceespu_branch_update_ctrl
// Purpose  : Buffers resolved conditional branches and trains the gshare
//            pattern table one entry per cycle, strictly in order, whenever
//            the table is free. Also emits a registered mispredict pulse.
// Options  : BP_UPDATE_STATS_EN adds saturating branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module ceespu_branch_update_ctrl #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              resolve_valid,
    output logic              resolve_ready,
    input  logic [ADDR_W-1:0] resolve_addr,
    input  logic [1:0]        resolve_state,
    input  logic              resolve_taken,
    input  logic              resolve_predicted,
    input  logic              upd_ready,
    output logic              update_table,
    output logic [ADDR_W-1:0] branch_address,
    output logic [1:0]        branch_prediction_state,
    output logic              branch_taken,
    output logic              mispredict,
    output logic              queue_empty
`ifdef BP_UPDATE_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int unsigned            c_DEPTH_INT = 1 << DEPTH_LOG2;
    localparam int                     c_ENTRY_W   = ADDR_W + 3;
    localparam logic [DEPTH_LOG2:0]    c_DEPTH     = (DEPTH_LOG2+1)'(c_DEPTH_INT);
    localparam logic [DEPTH_LOG2:0]    c_CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]    c_CNT_ZERO  = '0;
    localparam logic [DEPTH_LOG2-1:0]  c_PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_BLOCK = 2'd2
    } state_t;

    logic [c_ENTRY_W-1:0]  r_mem [c_DEPTH_INT];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_queue_empty;

    logic                  r_update_table;
    logic [ADDR_W-1:0]     r_branch_address;
    logic [1:0]            r_branch_state;
    logic                  r_branch_taken;
    logic                  r_mispredict;

    state_t                r_state;
    state_t                w_state_next;

    logic                  w_enq;
    logic                  w_deq;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [c_ENTRY_W-1:0]  w_entry_in;
    logic [c_ENTRY_W-1:0]  w_head;

    // Ready depends only on the registered count, so a full FIFO cannot
    // accept in the same cycle it drains.
    assign resolve_ready = (r_count != c_DEPTH);
    assign w_enq         = resolve_valid & resolve_ready;
    assign w_deq         = (r_count != c_CNT_ZERO) & upd_ready;
    assign w_entry_in    = {resolve_addr, resolve_state, resolve_taken};
    assign w_head        = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage needs no reset: only entries behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_queue_empty <= 1'b1;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count       <= w_count_next;
            r_queue_empty <= (w_count_next == c_CNT_ZERO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_update_table   <= 1'b0;
            r_branch_address <= '0;
            r_branch_state   <= 2'b00;
            r_branch_taken   <= 1'b0;
            r_mispredict     <= 1'b0;
        end else begin
            r_update_table <= w_deq;
            if (w_deq) begin
                {r_branch_address, r_branch_state, r_branch_taken} <= w_head;
            end
            r_mispredict <= w_enq & (resolve_taken ^ resolve_predicted);
        end
    end

    // Status FSM: tracks whether the queue is idle, draining or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_enq) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_count_next == c_CNT_ZERO) begin
                    w_state_next = S_IDLE;
                end else if (!upd_ready) begin
                    w_state_next = S_BLOCK;
                end
            end
            S_BLOCK: begin
                if (upd_ready) begin
                    w_state_next = (w_count_next == c_CNT_ZERO) ? S_IDLE : S_DRAIN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign update_table            = r_update_table;
    assign branch_address          = r_branch_address;
    assign branch_prediction_state = r_branch_state;
    assign branch_taken            = r_branch_taken;
    assign mispredict              = r_mispredict;
    assign queue_empty             = r_queue_empty;

`ifdef BP_UPDATE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_enq && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (r_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= c_DEPTH);
    a_empty_flag:  assert property (@(posedge clk) disable iff (!rst_n) r_queue_empty == (r_count == c_CNT_ZERO));

endmodule
`default_nettype wire

// File: tb/tb_ceespu_branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceespu_branch_update_ctrl
// Purpose  : Scoreboard bench for the branch update controller: directed
//            scenarios followed by randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ceespu_branch_update_ctrl;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_valid;
    logic        resolve_ready;
    logic [13:0] resolve_addr;
    logic [1:0]  resolve_state;
    logic        resolve_taken;
    logic        resolve_predicted;
    logic        upd_ready;
    logic        update_table;
    logic [13:0] branch_address;
    logic [1:0]  branch_prediction_state;
    logic        branch_taken;
    logic        mispredict;
    logic        queue_empty;
`ifdef BP_UPDATE_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    ceespu_branch_update_ctrl #(.DEPTH_LOG2(2), .ADDR_W(14)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .resolve_valid           (resolve_valid),
        .resolve_ready           (resolve_ready),
        .resolve_addr            (resolve_addr),
        .resolve_state           (resolve_state),
        .resolve_taken           (resolve_taken),
        .resolve_predicted       (resolve_predicted),
        .upd_ready               (upd_ready),
        .update_table            (update_table),
        .branch_address          (branch_address),
        .branch_prediction_state (branch_prediction_state),
        .branch_taken            (branch_taken),
        .mispredict              (mispredict),
        .queue_empty             (queue_empty)
`ifdef BP_UPDATE_STATS_EN
        ,
        .stat_branches           (stat_branches),
        .stat_mispredicts        (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [1:0]  st;
        logic        tk;
        int          cyc;
    } upd_t;

    upd_t        model_q[$];   // branches held by the controller
    upd_t        exp_upd[$];   // table writes expected, tagged with cycle
    int          exp_mis[$];   // cycles in which mispredict must be high
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          m_ready = 1;
    bit          m_empty = 1;
    logic [13:0] last_addr = '0;
    logic [1:0]  last_st = '0;
    logic        last_tk = 1'b0;
    int          m_stat_b = 0;
    int          m_stat_m = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model advances as the next edge will.
    task automatic drive_cycle(input bit v, input logic [13:0] a, input logic [1:0] s,
                               input bit tk, input bit pr, input bit ur, output bit acc);
        upd_t e;
        @(posedge clk);
        #1;
        resolve_valid     = v;
        resolve_addr      = a;
        resolve_state     = s;
        resolve_taken     = tk;
        resolve_predicted = pr;
        upd_ready         = ur;
        m_ready = (model_q.size() != c_DEPTH);
        m_empty = (model_q.size() == 0);
        acc = v && m_ready;
        if (ur && model_q.size() != 0) begin
            e = model_q.pop_front();
            e.cyc = cyc + 1;
            exp_upd.push_back(e);
        end
        if (acc) begin
            e.addr = a; e.st = s; e.tk = tk; e.cyc = 0;
            model_q.push_back(e);
            m_stat_b++;
            if (tk != pr) begin
                exp_mis.push_back(cyc + 1);
                m_stat_m++;
            end
        end
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, 0, 1, acc);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            upd_t e;
            chk("resolve_ready", resolve_ready, m_ready);
            chk("queue_empty", queue_empty, m_empty);
            if (exp_upd.size() > 0 && exp_upd[0].cyc == cyc) begin
                e = exp_upd.pop_front();
                chk("update_table", update_table, 1);
                chk("upd_addr", branch_address, e.addr);
                chk("upd_state", branch_prediction_state, e.st);
                chk("upd_taken", branch_taken, e.tk);
                last_addr = e.addr; last_st = e.st; last_tk = e.tk;
            end else begin
                chk("update_table_idle", update_table, 0);
                chk("hold_addr", {branch_address, branch_prediction_state, branch_taken},
                    {last_addr, last_st, last_tk});
            end
            if (exp_mis.size() > 0 && exp_mis[0] == cyc) begin
                void'(exp_mis.pop_front());
                chk("mispredict", mispredict, 1);
            end else begin
                chk("mispredict_idle", mispredict, 0);
            end
        end
    end

    task automatic reset_mid;
        @(posedge clk);
        #3;
        chk("pre_reset_update", update_table,
            (exp_upd.size() > 0 && exp_upd[0].cyc == cyc) ? 1 : 0);
        mon_en = 0;
        rst_n = 0;
        resolve_valid = 0;
        #1;
        chk("rst_update_table", update_table, 0);
        chk("rst_queue_empty", queue_empty, 1);
        chk("rst_ready", resolve_ready, 1);
        chk("rst_addr", branch_address, 0);
        chk("rst_mispredict", mispredict, 0);
        model_q.delete(); exp_upd.delete(); exp_mis.delete();
        last_addr = '0; last_st = '0; last_tk = 1'b0;
        m_stat_b = 0; m_stat_m = 0;
        @(posedge clk);
        #3;
        rst_n = 1;
    endtask

    initial begin
        bit          acc;
        logic [13:0] ba [5];
        logic [1:0]  bs [5];
        bit          bt [5];
        int          idx;
        bit          pend;
        logic [13:0] pa;
        logic [1:0]  ps;
        bit          pt, pp;

        rst_n = 0; resolve_valid = 0; resolve_addr = '0; resolve_state = '0;
        resolve_taken = 0; resolve_predicted = 0; upd_ready = 0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1;
        #1;
        chk("reset_update_table", update_table, 0);
        chk("reset_mispredict", mispredict, 0);
        chk("reset_queue_empty", queue_empty, 1);
        chk("reset_ready", resolve_ready, 1);
        chk("reset_addr", branch_address, 0);
        chk("reset_state", branch_prediction_state, 0);
        chk("reset_taken", branch_taken, 0);

        // Single correctly predicted branch
        drive_cycle(1, 14'h0123, 2'd2, 1, 1, 1, acc);
        idle(4);

        // Mispredicted branch still trains with its real outcome
        drive_cycle(1, 14'h2abc, 2'd1, 0, 1, 1, acc);
        idle(4);

        // Back-pressure: table busy, five branches offered, fifth held
        for (int i = 0; i < 5; i++) begin
            ba[i] = 14'h0100 + 14'(i); bs[i] = 2'(i); bt[i] = 1'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            int k = (idx < 5) ? idx : 0;
            drive_cycle(idx < 5, ba[k], bs[k], bt[k], bt[k], c >= 6, acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 5);
        idle(3);

        // Blocking mid-drain
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 14'h0200 + 14'(i), 2'(i + 1), i[0], 0, 0, acc);
        drive_cycle(0, '0, '0, 0, 0, 1, acc);
        drive_cycle(0, '0, '0, 0, 0, 0, acc);
        drive_cycle(0, '0, '0, 0, 0, 1, acc);
        drive_cycle(0, '0, '0, 0, 0, 1, acc);
        idle(3);

        // Async reset with entries still queued
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 14'h0300 + 14'(i), 2'd3, 1, 0, 0, acc);
        drive_cycle(0, '0, '0, 0, 0, 1, acc);
        reset_mid();
        idle(5);

        // Randomized traffic; an unaccepted branch is held and re-presented
        pend = 0; pa = '0; ps = '0; pt = 0; pp = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend && $urandom_range(0, 9) < 6) begin
                pend = 1;
                pa = 14'($urandom); ps = 2'($urandom);
                pt = 1'($urandom); pp = 1'($urandom);
            end
            drive_cycle(pend, pa, ps, pt, pp, $urandom_range(0, 9) < 7, acc);
            if (acc) pend = 0;
        end
        idle(8);
        @(negedge clk);
        #1;
        chk("final_updates_drained", exp_upd.size(), 0);
        chk("final_mispredicts_seen", exp_mis.size(), 0);
`ifdef BP_UPDATE_STATS_EN
        chk("stat_branches", stat_branches, m_stat_b);
        chk("stat_mispredicts", stat_mispredicts, m_stat_m);
`endif
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ceespu_branch_update_ctrl.md
Name: ceespu_branch_update_ctrl

Overview:
Sequences pattern-table training for the gshare branch predictor. Resolved conditional branches from execute are buffered in a small FIFO. Entries are drained one per cycle into the predictor's update port (address, old 2-bit state, outcome, update strobe), only while the predictor table is free. A registered mispredict pulse is produced for the fetch/flush logic.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries).
ADDR_W, 14, branch PC width, matching the predictor address port.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
resolve_valid  in  1  execute stage presents a resolved conditional branch.
resolve_ready  out  1  controller accepts the branch this cycle.
resolve_addr  in  ADDR_W  branch PC.
resolve_state  in  2  predictor state captured at fetch time.
resolve_taken  in  1  actual outcome.
resolve_predicted  in  1  direction predicted at fetch.
upd_ready  in  1  predictor table free for a write this cycle (fetch has no conflicting access).
update_table  out  1  write strobe to predictor.
branch_address  out  ADDR_W  address for the table write.
branch_prediction_state  out  2  old state for the table write.
branch_taken  out  1  outcome for the table write.
mispredict  out  1  one-cycle pulse: an accepted branch was mispredicted.
queue_empty  out  1  FIFO empty.

Behaviour:
- Reset (rst_n low, async):
  - FIFO pointers and count cleared; FSM in S_IDLE.
  - update_table=0, mispredict=0, queue_empty=1, resolve_ready=1.
  - branch_address=0, branch_prediction_state=0, branch_taken=0.
- Reset asserted mid-operation discards all queued entries. No partial update strobe is emitted.
- FIFO: depth 2**DEPTH_LOG2, entry = {addr, state, taken}. Pointers are DEPTH_LOG2 bits and wrap naturally. count is DEPTH_LOG2+1 bits.
- resolve_ready = (count != DEPTH).
  - At full, no enqueue occurs even if a dequeue happens the same cycle; ready rises the cycle after count drops.
- Enqueue occurs when resolve_valid && resolve_ready.
- Simultaneous enqueue and dequeue: count is unchanged, both pointers advance.
- Dequeue occurs when the FIFO is non-empty and upd_ready=1. The head entry is registered onto branch_address/branch_prediction_state/branch_taken with update_table=1 for exactly one cycle.
- Latency: an entry accepted in cycle N on an empty FIFO with upd_ready=1 produces update_table high in cycle N+2. There is no bypass path.
- Update outputs are registered. When update_table=0, the data outputs hold their last values.
- FSM (status only; it drives no datapath):
  - S_IDLE: count==0. Moves to S_DRAIN on the first enqueue.
  - S_DRAIN: non-empty and upd_ready=1. Moves to S_BLOCK when upd_ready=0; to S_IDLE when the last entry dequeues with no concurrent enqueue.
  - S_BLOCK: non-empty and upd_ready=0. Returns to S_DRAIN when upd_ready=1.
- queue_empty is registered and equals (count==0) after each edge.
- mispredict is registered high in cycle N+1 when an accepted branch in cycle N has resolve_taken != resolve_predicted.
  - Branches not accepted (resolve_ready=0) generate no pulse. Execute must hold them and re-present.
- Entries drain strictly in order. This preserves the predictor's global-history ordering.

Optional Feature:
BP_UPDATE_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0]:
  - Reset to 0.
  - stat_branches increments on each accepted branch; stat_mispredicts increments on each mispredict pulse.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then single branch: addr=14'h0123, state=2, taken=1, predicted=1, upd_ready=1 -> update_table high 2 cycles later with addr 0x0123/state 2/taken 1; mispredict stays 0; queue_empty returns to 1.
- Mispredict: taken=0, predicted=1 accepted -> mispredict=1 for exactly one cycle, the cycle after acceptance; training still issued with taken=0.
- Back-pressure: upd_ready=0, 5 consecutive valids -> 4 accepted, resolve_ready=0 from the cycle after the 4th. Then upd_ready=1 -> 4 updates on consecutive cycles in order; ready reasserts; the 5th branch is accepted and drains last.
- Blocking mid-drain: 3 entries queued, upd_ready toggles 1,0,1,1 -> updates only in cycles with upd_ready=1; FSM passes S_DRAIN→S_BLOCK→S_DRAIN→S_IDLE.
- Async reset mid-drain: rst_n low between edges with 3 entries queued -> update_table drops immediately, queue_empty=1, no further updates after release.
- (BP_UPDATE_STATS_EN) 10 branches with 3 mispredicts -> stat_branches=10, stat_mispredicts=3; preload near saturation -> stays 32'hFFFF_FFFF.
